// File: rtl/smac_pkg.sv
// -----------------------------------------------------------------------------
// smac_pkg
// Shared definitions for the SMAC accumulator and its output stage.
//   acc_w()  : width of a finished dot-product sum, also used by AC3 ports
//   slot_t   : accumulator slot index (AC3 w_en encoding)
//   SHIFT_W  : width of the requantisation shift amount
// -----------------------------------------------------------------------------
package smac_pkg;

    localparam int SHIFT_W = 5;

    typedef logic [1:0] slot_t;

    // One bit per doubling of group size, operand precisions, accumulation
    // length, plus a sign bit.
    function automatic int acc_w(input int m, input int pa, input int pw, input int mno);
        return $clog2(m) + pa + pw + $clog2(mno) + 1;
    endfunction

endpackage

// File: rtl/smac_out_fifo.sv
// -----------------------------------------------------------------------------
// smac_out_fifo
// Small synchronous FIFO with a registered head (no write-to-read bypass).
//   clk, rst    : clock, asynchronous active-high reset
//   push        : write push_data this cycle
//   push_data   : entry to store
//   pop_ready   : consumer accepts the head; a pop happens when head_valid too
//   head_valid  : FIFO not empty
//   head_data   : oldest entry, stable until popped
//   count       : number of stored entries (0..DEPTH)
// A push into a full FIFO is accepted only together with a pop.
// -----------------------------------------------------------------------------
module smac_out_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop_ready,
    output logic                         head_valid,
    output logic [W-1:0]                 head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop;
    logic             do_push;

    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];
    assign pop        = head_valid && pop_ready;
    // When full, the slot being written is the head being popped this cycle.
    assign do_push    = push && ((count != CNT_W'(DEPTH)) || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the storage is reset on purpose: it is only a few entries
            // and the head must read as zero straight out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/smac_requant_out.sv
// -----------------------------------------------------------------------------
// smac_requant_out
// Output stage behind the AC3 accumulator: bias add, round-half-up arithmetic
// right shift, optional ReLU, saturation to Pa bits, then an output FIFO.
//   clk, rst             : clock, asynchronous active-high reset
//   acc_valid/acc_ready  : finished sum handshake (acc_in, slot acc_sel)
//   bias_we/sel/in       : write one of the four per-slot bias registers
//   shift, relu_en       : requantisation controls (static while busy)
//   out_valid/out_ready  : activation handshake (out_data, tag out_slot)
//   sat_flag, drop_err   : sticky status, cleared by clr_flags
// Pipeline: S1 (bias add) -> S2 (requant) -> FIFO. The pipeline never stalls;
// acc_ready is issued from credits so every accepted sum has a FIFO slot.
// -----------------------------------------------------------------------------
module smac_requant_out
    import smac_pkg::*;
#(
    parameter int  M     = 16,
    parameter int  Pa    = 8,
    parameter int  Pw    = 4,
    parameter int  MNO   = 288,
    parameter int  DEPTH = 4,
    localparam int ACC_W = acc_w(M, Pa, Pw, MNO)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     acc_valid,
    output logic                     acc_ready,
    input  slot_t                    acc_sel,
    input  logic signed [ACC_W-1:0]  acc_in,
    input  logic                     bias_we,
    input  slot_t                    bias_sel,
    input  logic signed [ACC_W-1:0]  bias_in,
    input  logic [SHIFT_W-1:0]       shift,
    input  logic                     relu_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [Pa-1:0]     out_data,
    output slot_t                    out_slot,
    output logic                     sat_flag,
    output logic                     drop_err,
    input  logic                     clr_flags
);

    localparam int CNT_W    = $clog2(DEPTH+1);
    localparam int SAT_HI_I = 2**(Pa-1) - 1;
    localparam int SAT_LO_I = -(2**(Pa-1));
    localparam logic signed [ACC_W+1:0] SAT_HI = (ACC_W+2)'(SAT_HI_I);
    localparam logic signed [ACC_W+1:0] SAT_LO = (ACC_W+2)'(SAT_LO_I);

    logic signed [ACC_W-1:0] bias_q [4];

    logic                    s1_v;
    slot_t                   s1_slot;
    logic signed [ACC_W:0]   s1_sum;

    logic                    s2_v;
    slot_t                   s2_slot;
    logic signed [Pa-1:0]    s2_data;

    logic [CNT_W-1:0]        fifo_count;
    logic [CNT_W:0]          in_flight;
    logic                    accept;
    logic                    drop_event;

    logic signed [ACC_W+1:0] wide;
    logic signed [ACC_W+1:0] rnd;
    logic signed [ACC_W+1:0] sum2;
    logic signed [Pa-1:0]    requant;
    logic                    sat_hit;

    logic [Pa+1:0]           head;

    // Everything in S1, S2 or the FIFO holds a slot; refuse new sums once all
    // DEPTH slots are spoken for.
    assign in_flight  = {1'b0, fifo_count} + (CNT_W+1)'(s1_v) + (CNT_W+1)'(s2_v);
    assign acc_ready  = (in_flight < (CNT_W+1)'(DEPTH));
    assign accept     = acc_valid && acc_ready;
    assign drop_event = acc_valid && !acc_ready;

    // S2 requantisation arithmetic on the S1 register.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves a value held, which would infer a latch.
        wide    = {s1_sum[ACC_W], s1_sum};
        rnd     = '0;
        sat_hit = 1'b0;
        if (shift != '0) begin
            rnd = (ACC_W+2)'(1) << (shift - SHIFT_W'(1));
        end
        sum2    = (shift != '0) ? ((wide + rnd) >>> shift) : wide;
        requant = sum2[Pa-1:0];
        // ReLU takes priority and is not counted as saturation.
        if (relu_en && sum2[ACC_W+1]) begin
            requant = '0;
        end else if (sum2 > SAT_HI) begin
            requant = Pa'(SAT_HI_I);
            sat_hit = 1'b1;
        end else if (sum2 < SAT_LO) begin
            requant = Pa'(SAT_LO_I);
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                bias_q[i] <= '0;
            end
            s1_v     <= 1'b0;
            s1_slot  <= '0;
            s1_sum   <= '0;
            s2_v     <= 1'b0;
            s2_slot  <= '0;
            s2_data  <= '0;
            sat_flag <= 1'b0;
            drop_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so S1 reads the bias
            // value from before a same-cycle bias write.
            if (bias_we) begin
                bias_q[bias_sel] <= bias_in;
            end

            s1_v <= accept;
            if (accept) begin
                s1_slot <= acc_sel;
                s1_sum  <= {acc_in[ACC_W-1], acc_in}
                         + {bias_q[acc_sel][ACC_W-1], bias_q[acc_sel]};
            end

            s2_v <= s1_v;
            if (s1_v) begin
                s2_slot <= s1_slot;
                s2_data <= requant;
            end

            // Set events beat a same-cycle clear.
            if (s1_v && sat_hit) begin
                sat_flag <= 1'b1;
            end else if (clr_flags) begin
                sat_flag <= 1'b0;
            end

            if (drop_event) begin
                drop_err <= 1'b1;
            end else if (clr_flags) begin
                drop_err <= 1'b0;
            end
        end
    end

    smac_out_fifo #(
        .W     (Pa + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (s2_v),
        .push_data  ({s2_slot, s2_data}),
        .pop_ready  (out_ready),
        .head_valid (out_valid),
        .head_data  (head),
        .count      (fifo_count)
    );

    assign out_slot = head[Pa+1:Pa];
    assign out_data = head[Pa-1:0];

endmodule
